inst_loader: RTL and testbench

- Writer side of the CPU instruction memory: receives a program as a byte stream from the UART receiver and writes 32-bit instruction words into the instruction RAM's write port.
- Sits between the UART RX byte interface and the instruction memory during boot.
- Signals completion to the core via done.
- Returns an acknowledge byte to the host through the UART TX handshake.

---
 rtl/inst_loader.sv | 159 +++++++++++++++
 tb/tb_inst_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction loader: assembles a big-endian byte stream from the UART
// into 32-bit words, writes them to instruction RAM and acknowledges the host.
module inst_loader #(
  parameter int unsigned MAX_WORDS = 15001,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_ACK    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BCNT_W-1:0] byte_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] n_words;
  logic [WORD_W-1:0] word_cnt;

  logic              accept_c;
  logic              last_byte_c;
  logic [WORD_W-1:0] word_c;
  logic [WORD_W-1:0] word_inc_c;

  logic              we_d;
  logic [WORD_W-1:0] wa_d;
  logic [WORD_W-1:0] wd_d;
  logic              err_d;
  logic              tx_valid_d;
  logic [7:0]        tx_data_d;
  logic              done_d;
  logic              busy_d;

  // Bytes are only consumed while a program is still expected.
  assign accept_c    = rx_valid && ((state == S_HEADER) || (state == S_DATA));
  assign last_byte_c = accept_c && (byte_cnt == BCNT_W'(3));
  assign word_c      = {shreg[WORD_W-9:0], rx_data};
  assign word_inc_c  = word_cnt + WORD_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HEADER;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_HEADER: begin
        if (last_byte_c) begin
          state_nxt = (word_c != '0) ? S_DATA : S_ACK;
        end
      end
      S_DATA: begin
        if (last_byte_c && (word_inc_c == n_words)) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_valid && tx_ready) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_HEADER;
    endcase
  end

  // Next values of the registered outputs; write port holds its last address/data.
  always_comb begin
    we_d       = 1'b0;
    wa_d       = wa;
    wd_d       = wd;
    err_d      = err;
    tx_valid_d = (state_nxt == S_ACK);
    tx_data_d  = (state_nxt == S_ACK) ? ACK_BYTE : tx_data;
    done_d     = (state_nxt == S_DONE);
    busy_d     = (state_nxt != S_DONE);
    if ((state == S_DATA) && last_byte_c) begin
      if (word_cnt < WORD_W'(MAX_WORDS)) begin
        we_d = 1'b1;
        wa_d = WORD_W'(BASE_ADDR) + word_cnt;
        wd_d = word_c;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Byte assembly and word bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      shreg    <= '0;
      n_words  <= '0;
      word_cnt <= '0;
    end else begin
      if (accept_c) begin
        shreg    <= word_c;
        byte_cnt <= byte_cnt + BCNT_W'(1);
      end
      if ((state == S_HEADER) && last_byte_c) begin
        n_words  <= word_c;
        word_cnt <= '0;
      end
      if ((state == S_DATA) && last_byte_c) begin
        word_cnt <= word_inc_c;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      err      <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
      busy     <= 1'b1;
    end else begin
      we       <= we_d;
      wa       <= wa_d;
      wd       <= wd_d;
      err      <= err_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances (default depth and MAX_WORDS=2) driven by
// the same random byte streams, checked against a per-word write model.
module tb_inst_loader;

  localparam int unsigned MAX_A = 15001;
  localparam int unsigned MAX_B = 2;
  localparam logic [7:0]  ACK   = 8'hAA;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;

  logic        tx_valid_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  tx_data_a;
  logic [31:0] wa_a, wd_a;
  logic        tx_valid_b, we_b, busy_b, done_b, err_b;
  logic [7:0]  tx_data_b;
  logic [31:0] wa_b, wd_b;

  inst_loader dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
    .we(we_a), .wa(wa_a), .wd(wd_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  inst_loader #(.MAX_WORDS(MAX_B)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
    .we(we_b), .wa(wa_b), .wd(wd_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  logic [31:0] exp_a_cyc[$], exp_a_wa[$], exp_a_wd[$];
  logic [31:0] exp_b_cyc[$], exp_b_wa[$], exp_b_wd[$];
  logic [31:0] obs_a_cyc[$], obs_a_wa[$], obs_a_wd[$];
  logic [31:0] obs_b_cyc[$], obs_b_wa[$], obs_b_wd[$];
  logic [31:0] words_q[$];

  // Record every write pulse together with the edge it followed.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (we_a) begin
        obs_a_cyc.push_back(cyc); obs_a_wa.push_back(wa_a); obs_a_wd.push_back(wd_a);
      end
      if (we_b) begin
        obs_b_cyc.push_back(cyc); obs_b_wa.push_back(wa_b); obs_b_wd.push_back(wd_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_queues();
    exp_a_cyc.delete(); exp_a_wa.delete(); exp_a_wd.delete();
    exp_b_cyc.delete(); exp_b_wa.delete(); exp_b_wd.delete();
    obs_a_cyc.delete(); obs_a_wa.delete(); obs_a_wd.delete();
    obs_b_cyc.delete(); obs_b_wa.delete(); obs_b_wd.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_queues();
  endtask

  // Present one byte for one cycle, then idle for gap cycles; at = edge that samples it.
  task automatic drive_byte(input logic [7:0] b, input int gap, output int unsigned at);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    at = cyc + 1;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic end_drive();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic cmp_writes();
    int m;
    check("nwrites_a", obs_a_wa.size(), exp_a_wa.size());
    m = (obs_a_wa.size() < exp_a_wa.size()) ? obs_a_wa.size() : exp_a_wa.size();
    for (int i = 0; i < m; i++) begin
      check("wa_a", obs_a_wa[i], exp_a_wa[i]);
      check("wd_a", obs_a_wd[i], exp_a_wd[i]);
      check("we_cyc_a", obs_a_cyc[i], exp_a_cyc[i]);
    end
    check("nwrites_b", obs_b_wa.size(), exp_b_wa.size());
    m = (obs_b_wa.size() < exp_b_wa.size()) ? obs_b_wa.size() : exp_b_wa.size();
    for (int i = 0; i < m; i++) begin
      check("wa_b", obs_b_wa[i], exp_b_wa[i]);
      check("wd_b", obs_b_wd[i], exp_b_wd[i]);
      check("we_cyc_b", obs_b_cyc[i], exp_b_cyc[i]);
    end
  endtask

  // Send header + words_q, then complete the ack handshake after ready_delay cycles.
  task automatic run_stream(input int gap_max, input int ready_delay);
    int unsigned at;
    int          n;
    int          k;
    logic [31:0] hdr;
    logic [31:0] w;
    n   = words_q.size();
    hdr = 32'(n);
    for (int j = 0; j < 4; j++)
      drive_byte(hdr[31-8*j -: 8], $urandom_range(gap_max, 0), at);
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int j = 0; j < 4; j++)
        drive_byte(w[31-8*j -: 8], $urandom_range(gap_max, 0), at);
      if (i < int'(MAX_A)) begin
        exp_a_cyc.push_back(at); exp_a_wa.push_back(32'(i)); exp_a_wd.push_back(w);
      end
      if (i < int'(MAX_B)) begin
        exp_b_cyc.push_back(at); exp_b_wa.push_back(32'(i)); exp_b_wd.push_back(w);
      end
    end
    end_drive();
    k = 0;
    while (!(tx_valid_a && tx_valid_b) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ack_valid", 32'({tx_valid_a, tx_valid_b}), 32'h3);
    check("ack_data_a", 32'(tx_data_a), 32'(ACK));
    check("ack_data_b", 32'(tx_data_b), 32'(ACK));
    check("busy_in_ack", 32'({busy_a, done_a}), 32'h2);
    repeat (ready_delay) begin
      @(negedge clk);
      check("ack_hold_valid", 32'({tx_valid_a, tx_valid_b}), 32'h3);
      check("ack_hold_data", 32'(tx_data_a), 32'(ACK));
    end
    @(negedge clk);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("done_a", 32'({done_a, busy_a, tx_valid_a}), 32'h4);
    check("done_b", 32'({done_b, busy_b, tx_valid_b}), 32'h4);
    @(negedge clk);
    tx_ready = 1'b0;
    cmp_writes();
    check("err_a", 32'(err_a), 32'(n > int'(MAX_A)));
    check("err_b", 32'(err_b), 32'(n > int'(MAX_B)));
  endtask

  initial begin
    int unsigned at;
    int          sz_a;
    int          sz_b;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    do_reset();

    check("rst_we_wa_wd", 32'(we_a) | wa_a | wd_a, 32'h0);
    check("rst_tx", 32'({tx_valid_a, tx_data_a}), 32'h0);
    check("rst_flags", 32'({busy_a, done_a, err_a}), 32'h4);
    check("rst_flags_b", 32'({busy_b, done_b, err_b}), 32'h4);

    // Two-word program, back-to-back bytes
    words_q = '{32'h12345678, 32'hDEADBEEF};
    run_stream(0, 0);

    // Empty program: straight to ack
    do_reset();
    words_q.delete();
    run_stream(0, 0);

    // Host stalls the ack for 10 cycles
    do_reset();
    words_q = '{32'hCAFEF00D};
    run_stream(1, 10);

    // Three words: the small-depth instance suppresses the third and flags err
    do_reset();
    words_q = '{32'h00000011, 32'h00000022, 32'h00000033};
    run_stream(0, 2);

    // Extra bytes after DONE are ignored
    sz_a = obs_a_wa.size();
    sz_b = obs_b_wa.size();
    for (int i = 0; i < 6; i++) drive_byte(8'($urandom), 0, at);
    end_drive();
    repeat (3) @(negedge clk);
    check("post_done_writes_a", 32'(obs_a_wa.size()), 32'(sz_a));
    check("post_done_writes_b", 32'(obs_b_wa.size()), 32'(sz_b));
    check("post_done_flags", 32'({done_a, busy_a, tx_valid_a}), 32'h4);

    // Reset after header plus two data bytes; partial word must vanish
    do_reset();
    drive_byte(8'h00, 0, at); drive_byte(8'h00, 0, at);
    drive_byte(8'h00, 0, at); drive_byte(8'h01, 0, at);
    drive_byte(8'h12, 0, at); drive_byte(8'h34, 0, at);
    end_drive();
    do_reset();
    check("midrst_busy", 32'({busy_a, done_a}), 32'h2);
    words_q = '{32'h00000013};
    run_stream(0, 0);

    // Random programs with random byte gaps and ack stalls
    for (int t = 0; t < 8; t++) begin
      do_reset();
      words_q.delete();
      for (int i = 0; i < int'($urandom_range(5, 0)); i++) words_q.push_back($urandom);
      run_stream(int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
